// File: rtl/hilo_div_ctrl.sv
// HI/LO register file and multi-cycle divider sequencer for the EX stage.
// Optional build macro DIV_FAST_EN: a divide by 1 completes in IDLE without the divider.
module hilo_div_ctrl #(
    parameter logic [31:0] HILO_RESET = 32'h0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ex_valid,
    input  logic [2:0]  ex_op,
    input  logic [31:0] ex_rs,
    input  logic [31:0] ex_rt,
    input  logic        flush,
    output logic        stall_req,
    output logic [31:0] mf_data,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        div_start,
    output logic        div_cancel,
    output logic        div_signed,
    output logic [31:0] div_op1,
    output logic [31:0] div_op2,
    input  logic        div_ready,
    input  logic [63:0] div_result
);

    typedef enum logic [2:0] {
        OP_NONE = 3'b000,
        OP_DIV  = 3'b001,
        OP_DIVU = 3'b010,
        OP_MTHI = 3'b011,
        OP_MTLO = 3'b100,
        OP_MFHI = 3'b101,
        OP_MFLO = 3'b110
    } op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e      state;
    logic [63:0] res_q;
    logic        is_div;
    logic        issue;
    logic        fast_hit;
    logic        issue_slow;

    assign is_div = (ex_op == OP_DIV) || (ex_op == OP_DIVU);
    assign issue  = (state == IDLE) && ex_valid && is_div && !flush;

`ifdef DIV_FAST_EN
    assign fast_hit = (ex_rt == 32'd1);
`else
    assign fast_hit = 1'b0;
`endif

    assign issue_slow = issue && !fast_hit;

    // Gated by rst so a squashed pipeline sees no stall while reset is held.
    assign stall_req = rst && (issue_slow || (state == BUSY));

    always_comb begin
        mf_data = 32'h0;
        if (ex_op == OP_MFHI)
            mf_data = hi;
        else if (ex_op == OP_MFLO)
            mf_data = lo;
    end

    // NOTE: every register here is assigned with <= so all updates see pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= IDLE;
            div_start  <= 1'b0;
            div_cancel <= 1'b0;
            div_signed <= 1'b0;
            div_op1    <= 32'h0;
            div_op2    <= 32'h0;
            res_q      <= 64'h0;
            hi         <= HILO_RESET;
            lo         <= HILO_RESET;
        end else begin
            div_cancel <= 1'b0;
            case (state)
                IDLE: begin
                    if (issue_slow) begin
                        div_op1    <= ex_rs;
                        div_op2    <= ex_rt;
                        div_signed <= (ex_op == OP_DIV);
                        div_start  <= 1'b1;
                        state      <= BUSY;
                    end else if (issue) begin
                        // Divisor of 1: quotient is the dividend, remainder is zero.
                        lo <= ex_rs;
                        hi <= 32'h0;
                    end else if (ex_valid && !flush) begin
                        if (ex_op == OP_MTHI)
                            hi <= ex_rs;
                        if (ex_op == OP_MTLO)
                            lo <= ex_rs;
                    end
                end
                BUSY: begin
                    if (flush) begin
                        div_cancel <= 1'b1;
                        div_start  <= 1'b0;
                        state      <= IDLE;
                    end else if (div_ready) begin
                        res_q     <= div_result;
                        div_start <= 1'b0;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    // ex_op still names the retiring divide, so it is not decoded here.
                    if (!flush) begin
                        hi <= res_q[63:32];
                        lo <= res_q[31:0];
                    end
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_hilo_div_ctrl.sv
// Directed self-checking bench for hilo_div_ctrl; the bench plays the divider itself.
module tb_hilo_div_ctrl;

    localparam logic [31:0] RV = 32'hA5A5_0001;

    logic        clk = 1'b0;
    logic        rst;
    logic        ex_valid;
    logic [2:0]  ex_op;
    logic [31:0] ex_rs;
    logic [31:0] ex_rt;
    logic        flush;
    logic        stall_req;
    logic [31:0] mf_data;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        div_start;
    logic        div_cancel;
    logic        div_signed;
    logic [31:0] div_op1;
    logic [31:0] div_op2;
    logic        div_ready;
    logic [63:0] div_result;

    int checks = 0;
    int errors = 0;

    hilo_div_ctrl #(.HILO_RESET(RV)) dut (
        .clk(clk), .rst(rst), .ex_valid(ex_valid), .ex_op(ex_op), .ex_rs(ex_rs),
        .ex_rt(ex_rt), .flush(flush), .stall_req(stall_req), .mf_data(mf_data),
        .hi(hi), .lo(lo), .div_start(div_start), .div_cancel(div_cancel),
        .div_signed(div_signed), .div_op1(div_op1), .div_op2(div_op2),
        .div_ready(div_ready), .div_result(div_result)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        ex_valid = 1'b0; ex_op = 3'b000; ex_rs = 32'h0; ex_rt = 32'h0;
        flush = 1'b0; div_ready = 1'b0; div_result = 64'h0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        idle_inputs();
        ex_op = 3'b101;
        tick(); tick();
        checks++; if (hi !== RV) begin errors++; $display("FAIL reset_hi: got %h want %h", hi, RV); end
        checks++; if (lo !== RV) begin errors++; $display("FAIL reset_lo: got %h want %h", lo, RV); end
        checks++; if (mf_data !== RV) begin errors++; $display("FAIL reset_mf: got %h want %h", mf_data, RV); end
        checks++; if (div_start !== 1'b0 || div_cancel !== 1'b0) begin errors++; $display("FAIL reset_ctl: got start=%b cancel=%b want 0 0", div_start, div_cancel); end
        checks++; if (div_op1 !== 32'h0 || div_op2 !== 32'h0 || div_signed !== 1'b0) begin errors++; $display("FAIL reset_ops: got %h %h %b want 0 0 0", div_op1, div_op2, div_signed); end
        ex_valid = 1'b1; ex_op = 3'b001; ex_rs = 32'd9; ex_rt = 32'd2;
        #1;
        checks++; if (stall_req !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b want 0", stall_req); end
        idle_inputs();
        rst = 1'b1;
        tick();
    endtask

    task automatic test_divu();
        ex_valid = 1'b1; ex_op = 3'b010; ex_rs = 32'd100; ex_rt = 32'd7;
        #1;
        checks++; if (stall_req !== 1'b1) begin errors++; $display("FAIL divu_issue_stall: got %b want 1", stall_req); end
        tick();
        checks++; if (div_start !== 1'b1) begin errors++; $display("FAIL divu_start: got %b want 1", div_start); end
        checks++; if (div_op1 !== 32'd100 || div_op2 !== 32'd7 || div_signed !== 1'b0) begin errors++; $display("FAIL divu_ops: got %h %h %b want 64 7 0", div_op1, div_op2, div_signed); end
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (div_start !== 1'b1 || stall_req !== 1'b1) begin errors++; $display("FAIL divu_busy_hold: got start=%b stall=%b want 1 1", div_start, stall_req); end
        end
        div_ready = 1'b1; div_result = {32'd2, 32'd14};
        #1;
        checks++; if (stall_req !== 1'b1) begin errors++; $display("FAIL divu_ready_stall: got %b want 1", stall_req); end
        tick();
        div_ready = 1'b0; div_result = 64'h0;
        #1;
        checks++; if (stall_req !== 1'b0 || div_start !== 1'b0) begin errors++; $display("FAIL divu_done_ctl: got stall=%b start=%b want 0 0", stall_req, div_start); end
        tick();
        checks++; if (hi !== 32'd2) begin errors++; $display("FAIL divu_hi: got %h want 2", hi); end
        checks++; if (lo !== 32'd14) begin errors++; $display("FAIL divu_lo: got %h want e", lo); end
        checks++; if (div_start !== 1'b0 || stall_req !== 1'b1) begin errors++; $display("FAIL done_ignores_op: got start=%b stall=%b want 0 1", div_start, stall_req); end
        ex_valid = 1'b0;
        #1;
        checks++; if (stall_req !== 1'b0) begin errors++; $display("FAIL divu_idle_stall: got %b want 0", stall_req); end
        idle_inputs();
        tick();
    endtask

    task automatic test_div_signed();
        ex_valid = 1'b1; ex_op = 3'b001; ex_rs = 32'hFFFF_FF9C; ex_rt = 32'd7;
        tick();
        checks++; if (div_signed !== 1'b1 || div_op1 !== 32'hFFFF_FF9C) begin errors++; $display("FAIL div_signed_ops: got %b %h want 1 ffffff9c", div_signed, div_op1); end
        tick();
        div_ready = 1'b1; div_result = {32'hFFFF_FFFE, 32'hFFFF_FFF2};
        tick();
        idle_inputs();
        tick();
        checks++; if (hi !== 32'hFFFF_FFFE || lo !== 32'hFFFF_FFF2) begin errors++; $display("FAIL div_signed_hilo: got %h %h want fffffffe fffffff2", hi, lo); end
    endtask

    task automatic test_flush_busy();
        ex_valid = 1'b1; ex_op = 3'b001; ex_rs = 32'd50; ex_rt = 32'd3;
        tick();
        for (int i = 2; i <= 5; i++) tick();
        flush = 1'b1; div_ready = 1'b1; div_result = {32'h11, 32'h22};
        #1;
        checks++; if (stall_req !== 1'b1) begin errors++; $display("FAIL flush_busy_stall: got %b want 1", stall_req); end
        tick();
        idle_inputs();
        #1;
        checks++; if (div_cancel !== 1'b1 || div_start !== 1'b0) begin errors++; $display("FAIL flush_cancel: got cancel=%b start=%b want 1 0", div_cancel, div_start); end
        checks++; if (stall_req !== 1'b0) begin errors++; $display("FAIL flush_stall_after: got %b want 0", stall_req); end
        tick();
        checks++; if (div_cancel !== 1'b0) begin errors++; $display("FAIL flush_cancel_pulse: got %b want 0", div_cancel); end
        checks++; if (hi !== 32'hFFFF_FFFE || lo !== 32'hFFFF_FFF2) begin errors++; $display("FAIL flush_hilo: got %h %h want fffffffe fffffff2", hi, lo); end
    endtask

    task automatic test_flush_done();
        ex_valid = 1'b1; ex_op = 3'b010; ex_rs = 32'd9; ex_rt = 32'd2;
        tick();
        div_ready = 1'b1; div_result = {32'd1, 32'd4};
        tick();
        idle_inputs();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        tick();
        checks++; if (hi !== 32'hFFFF_FFFE || lo !== 32'hFFFF_FFF2) begin errors++; $display("FAIL done_flush_hilo: got %h %h want fffffffe fffffff2", hi, lo); end
    endtask

    task automatic test_mt_mf();
        ex_valid = 1'b1; ex_op = 3'b011; ex_rs = 32'hDEAD;
        tick();
        ex_op = 3'b101; ex_rs = 32'h0;
        #1;
        checks++; if (mf_data !== 32'hDEAD) begin errors++; $display("FAIL mfhi: got %h want dead", mf_data); end
        ex_op = 3'b100; ex_rs = 32'hBEEF; flush = 1'b1;
        tick();
        flush = 1'b0; ex_op = 3'b110;
        #1;
        checks++; if (mf_data !== 32'hFFFF_FFF2) begin errors++; $display("FAIL mtlo_flushed: got %h want fffffff2", mf_data); end
        ex_op = 3'b100; ex_rs = 32'hBEEF;
        tick();
        checks++; if (lo !== 32'hBEEF) begin errors++; $display("FAIL mtlo: got %h want beef", lo); end
        ex_op = 3'b000;
        #1;
        checks++; if (mf_data !== 32'h0) begin errors++; $display("FAIL mf_none: got %h want 0", mf_data); end
        idle_inputs();
        tick();
    endtask

    task automatic test_reset_mid_busy();
        ex_valid = 1'b1; ex_op = 3'b001; ex_rs = 32'd20; ex_rt = 32'd3;
        tick();
        checks++; if (div_start !== 1'b1) begin errors++; $display("FAIL rst_busy_start: got %b want 1", div_start); end
        rst = 1'b0; ex_valid = 1'b0;
        tick();
        checks++; if (div_start !== 1'b0 || hi !== RV || lo !== RV) begin errors++; $display("FAIL rst_busy: got start=%b hi=%h lo=%h want 0 %h %h", div_start, hi, lo, RV, RV); end
        checks++; if (stall_req !== 1'b0) begin errors++; $display("FAIL rst_busy_stall: got %b want 0", stall_req); end
        rst = 1'b1; div_ready = 1'b1; div_result = {32'h77, 32'h66};
        tick();
        div_ready = 1'b0;
        tick();
        checks++; if (hi !== RV || lo !== RV) begin errors++; $display("FAIL rst_busy_abandon: got %h %h want %h %h", hi, lo, RV, RV); end
        idle_inputs();
    endtask

    task automatic test_div_by_one();
        ex_valid = 1'b1; ex_op = 3'b001; ex_rs = 32'd5; ex_rt = 32'd1;
        #1;
`ifdef DIV_FAST_EN
        checks++; if (stall_req !== 1'b0) begin errors++; $display("FAIL fast_stall: got %b want 0", stall_req); end
        tick();
        ex_valid = 1'b0;
        checks++; if (div_start !== 1'b0) begin errors++; $display("FAIL fast_start: got %b want 0", div_start); end
`else
        checks++; if (stall_req !== 1'b1) begin errors++; $display("FAIL by_one_stall: got %b want 1", stall_req); end
        tick();
        checks++; if (div_start !== 1'b1 || div_op2 !== 32'd1) begin errors++; $display("FAIL by_one_start: got %b %h want 1 1", div_start, div_op2); end
        div_ready = 1'b1; div_result = {32'd0, 32'd5};
        tick();
        idle_inputs();
        tick();
`endif
        checks++; if (lo !== 32'd5 || hi !== 32'd0) begin errors++; $display("FAIL by_one_hilo: got %h %h want 0 5", hi, lo); end
        idle_inputs();
        tick();
    endtask

    initial begin
        test_reset();
        test_divu();
        test_div_signed();
        test_flush_busy();
        test_flush_done();
        test_mt_mf();
        test_reset_mid_busy();
        test_div_by_one();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
